// File: rtl/light_pkg.sv
// Shared defaults and the counter-width helper for the light driver slice.
package light_pkg;

    localparam int KEY_W     = 7;
    localparam int BTN_W     = 3;
    localparam int HOLD_CYC  = 16;
    localparam int BLINK_DIV = 8;

    // Width that holds 0..max_val, never less than one bit so zero-length
    // counters cannot appear when a parameter is 0 or 1.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/light_stretch.sv
// One light channel: extends a level input by HOLD_CYC cycles after it falls.
module light_stretch #(
    parameter int HOLD_CYC = light_pkg::HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic lamp
);
    import light_pkg::*;

    localparam int CW = cnt_w(HOLD_CYC);

    logic [CW-1:0] cnt;

    // NOTE: reset is synchronous here, so it sits inside the clocked process
    // and is sampled like any other input; state updates use <= only.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (level) begin
            cnt <= CW'(HOLD_CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // Combinational so the top can register it together with the override.
    assign lamp = level | (cnt != '0);

endmodule

// File: rtl/light_driver.sv
// Key/button lamp stretching, replay blink and lamp-test override into one
// registered light vector.
module light_driver #(
    parameter int KEY_W     = light_pkg::KEY_W,
    parameter int BTN_W     = light_pkg::BTN_W,
    parameter int HOLD_CYC  = light_pkg::HOLD_CYC,
    parameter int BLINK_DIV = light_pkg::BLINK_DIV
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [KEY_W-1:0]       key,
    input  logic [BTN_W-1:0]       button,
    input  logic                   replay,
    input  logic                   lamp_test,
    output logic [KEY_W+BTN_W:0]   light
);
    import light_pkg::*;

    localparam int CH = KEY_W + BTN_W;
    localparam int BW = cnt_w(BLINK_DIV - 1);

    logic [CH-1:0] chan_in;
    logic [CH-1:0] lamps;

    assign chan_in = {button, key};

    for (genvar i = 0; i < CH; i++) begin : g_chan
        light_stretch #(.HOLD_CYC(HOLD_CYC)) u_stretch (
            .clk   (clk),
            .rst   (rst),
            .level (chan_in[i]),
            .lamp  (lamps[i])
        );
    end

    logic [BW-1:0] blink_cnt, blink_cnt_n;
    logic          phase, phase_n;
    logic          active;

    // The first replay edge starts a fresh on-phase; later edges count and
    // toggle the phase on each wrap.
    // NOTE: defaults are assigned first so no path leaves a latch behind.
    always_comb begin
        blink_cnt_n = '0;
        phase_n     = 1'b0;
        if (replay) begin
            if (!active) begin
                phase_n = 1'b1;
            end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
                phase_n = ~phase;
            end else begin
                blink_cnt_n = blink_cnt + BW'(1);
                phase_n     = phase;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
            active    <= 1'b0;
            light     <= '0;
        end else begin
            blink_cnt <= blink_cnt_n;
            phase     <= phase_n;
            active    <= replay;
            if (lamp_test) begin
                light <= '1;
            end else begin
                light <= {phase_n, lamps};
            end
        end
    end

endmodule

// File: doc/light_driver.md
LIGHT_DRIVER -- requirements
Module: light_driver

Interface
REQ-001 The block SHALL have parameter KEY_W, default 7, giving the number of piano-key light channels.
REQ-002 The block SHALL have parameter BTN_W, default 3, giving the number of button light channels.
REQ-003 The block SHALL have parameter HOLD_CYC, default 16, giving the extra on-time in cycles after a channel input falls; 0 means no stretch.
REQ-004 The block SHALL have parameter BLINK_DIV, default 8, giving the half-period in cycles of the replay blink.
REQ-005 The block SHALL have one clock and one reset; the reset SHALL be synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 key  input  KEY_W  level per key; 1 = pressed.
REQ-009 button  input  BTN_W  level per button; 1 = pressed.
REQ-010 replay  input  1  replay mode active.
REQ-011 lamp_test  input  1  forces every light on.
REQ-012 light  output  KEY_W+BTN_W+1  registered; packed as {replay lamp, button lamps, key lamps}, with key[0] at light[0].

Function
REQ-013 light SHALL be a register; an input change sampled at clock edge k SHALL appear on light after edge k (latency 1 cycle).
REQ-014 Each key/button channel i SHALL own a hold counter of width clog2(HOLD_CYC+1), reloaded to HOLD_CYC on every edge where its input is 1.
- Otherwise the counter decrements if nonzero and holds at 0.
REQ-015 The lamp of channel i SHALL be the registered value of (input_i OR counter_i != 0), so the lamp stays on for exactly HOLD_CYC cycles after the first edge at which the input samples 0.
REQ-016 A re-press during the hold SHALL keep the lamp continuously on, reload the counter, and start a fresh full HOLD_CYC on the next release.
REQ-017 A one-cycle input pulse SHALL produce a lamp on for exactly HOLD_CYC+1 cycles.
REQ-018 With HOLD_CYC=0, each lamp SHALL equal its input delayed by one cycle.
REQ-019 The replay lamp SHALL use a blink counter 0..BLINK_DIV-1 and a phase bit.
- The counter runs while replay=1.
- The phase toggles when the counter wraps from BLINK_DIV-1 to 0.
REQ-020 On the first edge where replay samples 1, the counter SHALL be 0 and the phase 1 (lamp on).
- The lamp is on for BLINK_DIV cycles, then off for BLINK_DIV cycles, repeating.
REQ-021 On any edge where replay samples 0, the blink counter SHALL clear to 0, the phase SHALL clear to 0, and the replay lamp SHALL be 0; no stretch applies to replay.
REQ-022 While lamp_test=1, every light bit SHALL be 1 from the next edge.
- Hold counters and blink state keep updating underneath.
- On release, light SHALL show the underlying state at the next edge.
REQ-023 All channels SHALL be fully independent; simultaneous events on multiple channels SHALL need no arbitration.

Reset
REQ-024 While rst=1 at a clock edge, light, all hold counters, the blink counter and the phase SHALL become 0; rst SHALL have priority over lamp_test and all inputs.
REQ-025 A reset asserted mid-hold or mid-blink SHALL cancel that hold or blink with no residual on-time after rst is released.
REQ-026 On the first edge after rst deasserts, outputs SHALL reflect the inputs per REQ-013.

Structure
REQ-027 A shared package light_pkg SHALL hold the default constants KEY_W, BTN_W, HOLD_CYC and BLINK_DIV, and a clog2-based counter-width helper.
REQ-028 The per-channel stretch SHALL be a sub-module light_stretch (one input, one lamp output, parameter HOLD_CYC), instantiated KEY_W+BTN_W times by generate.
REQ-029 The blink logic and the lamp_test override SHALL live in light_driver.

Verification
REQ-030 Reset case: rst held for 3 cycles with all inputs = 1 and lamp_test=1 -> light = 0 throughout; with inputs still 1, light = 11'h7FF one edge after release.
REQ-031 Stretch case: key[2] high for one cycle, HOLD_CYC=16 -> light[2] = 1 for exactly 17 cycles, and other bits stay 0.
REQ-032 Re-press case: button[0] pressed 4 cycles, released 5, pressed 2, released -> light[7] stays 1 continuously until 16 cycles after the final release.
REQ-033 Blink case: replay high for 40 cycles, BLINK_DIV=8 -> light[10] follows 8 on / 8 off / 8 on / 8 off / 8 on, then 0 on the first edge after replay falls.
REQ-034 Lamp-test case: lamp_test pulses for 3 cycles during a key[6] hold -> light = 11'h7FF for those 3 cycles, then light[6] resumes with its hold count unaffected.
REQ-035 Reset-during-hold case: rst pulses 5 cycles into a key[0] hold -> light[0] = 0 after that edge and stays 0 with key[0] low.
